// File: rtl/rr_fifo_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package rr_fifo_arbiter_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } arb_state_e;

    localparam int unsigned CountWidth = 8;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_fifo_arbiter_pick.sv
// Combinational round-robin search: first set bit of req starting after index last.
module rr_pick
    import rr_fifo_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            found,
    output logic [IW-1:0]   idx
);

    always_comb begin
        int unsigned cand;
        logic [IW-1:0] cand_idx;
        found    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        // Offsets 1..NREQ visit every requester once, ending at last itself.
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand     = (32'(last) + i) % NREQ;
            cand_idx = cand[IW-1:0];
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/rr_fifo_arbiter.sv
// Round-robin arbiter feeding an external FIFO write port in bursts of up to BURST_MAX beats.
// Define ARB_STATS_EN to add per-requester saturating beat counters (stat_clr / stat_beats).
module rr_fifo_arbiter
    import rr_fifo_arbiter_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DSIZE     = 32,
    parameter int unsigned BURST_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_last,
    input  logic [NREQ*DSIZE-1:0]    req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [DSIZE-1:0]         fifo_wdata,
    output logic                     fifo_winc,
    input  logic                     fifo_wfull,
    output logic [clog2(NREQ)-1:0]   grant_id,
    output logic                     busy
`ifdef ARB_STATS_EN
    ,
    input  logic                     stat_clr,
    output logic [NREQ*16-1:0]       stat_beats
`endif
);

    localparam int unsigned IW = clog2(NREQ);

    arb_state_e            state_q;
    logic [IW-1:0]         grant_q;
    logic [IW-1:0]         last_q;
    logic [CountWidth-1:0] count_q;
    logic [CountWidth-1:0] count_inc;
    logic                  pick_found;
    logic [IW-1:0]         pick_idx;
    logic                  burst_end;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req   (req_valid),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign busy       = (state_q == StGrant);
    assign grant_id   = grant_q;
    assign fifo_wdata = req_data[32'(grant_q)*DSIZE +: DSIZE];
    assign fifo_winc  = busy & req_valid[grant_q] & ~fifo_wfull;
    assign count_inc  = count_q + CountWidth'(1);
    assign burst_end  = fifo_winc &
                        (req_last[grant_q] | (count_inc == CountWidth'(BURST_MAX)));

    always_comb begin
        req_ready          = '0;
        req_ready[grant_q] = fifo_winc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= IW'(NREQ - 1);
            count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        state_q <= StGrant;
                        grant_q <= pick_idx;
                        count_q <= '0;
                    end
                end
                StGrant: begin
                    // A stalled or idle requester keeps the grant; only an accepted beat advances.
                    if (fifo_winc) begin
                        count_q <= count_inc;
                        if (burst_end) begin
                            state_q <= StIdle;
                            last_q  <= grant_q;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_stat
        logic [15:0] beats_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                beats_q <= '0;
            end else if (stat_clr) begin
                beats_q <= '0;
            end else if (req_ready[i] && (beats_q != 16'hffff)) begin
                beats_q <= beats_q + 16'd1;
            end
        end

        assign stat_beats[i*16 +: 16] = beats_q;
    end
`endif

endmodule
